// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module mips_muldiv #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hilo_read,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;

    stateT                stateReg, stateNext;
    logic [CW-1:0]        countReg, countNext;
    logic [2*WIDTH-1:0]   accReg, accNext;
    logic [WIDTH-1:0]     operandReg, operandNext;
    logic                 negReg, negNext;
    logic                 remNegReg, remNegNext;
    logic                 divZeroReg, divZeroNext;
    logic                 isDivReg, isDivNext;
    logic [WIDTH-1:0]     hiReg, hiNext;
    logic [WIDTH-1:0]     loReg, loNext;
    logic                 doneReg, doneNext;

    // Operand conditioning at issue
    logic             signedOp;
    logic             aNeg, bNeg;
    logic [WIDTH-1:0] magA, magB;

    assign signedOp = SIGNED_EN && !op[0];
    assign aNeg     = signedOp & src_a[WIDTH-1];
    assign bNeg     = signedOp & src_b[WIDTH-1];
    assign magA     = aNeg ? (~src_a + 1'b1) : src_a;
    assign magB     = bNeg ? (~src_b + 1'b1) : src_b;

    // One multiply iteration: add multiplicand on LSB, then shift the whole accumulator right
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulStep;

    assign mulSum  = {1'b0, accReg[2*WIDTH-1:WIDTH]}
                   + (accReg[0] ? {1'b0, operandReg} : {(WIDTH+1){1'b0}});
    assign mulStep = {mulSum, accReg[WIDTH-1:1]};

    // One divide iteration: upper half is the partial remainder, lower half shifts
    // dividend bits out and quotient bits in.
    logic [WIDTH:0]     divShift;
    logic [WIDTH-1:0]   divDiff;
    logic               divFits;
    logic [2*WIDTH-1:0] divStep;

    assign divShift = {accReg[2*WIDTH-1:WIDTH], accReg[WIDTH-1]};
    assign divFits  = (divShift >= {1'b0, operandReg});
    assign divDiff  = divShift[WIDTH-1:0] - operandReg;
    assign divStep  = {(divFits ? divDiff : divShift[WIDTH-1:0]), accReg[WIDTH-2:0], divFits};

    // Sign restoration applied in FIX
    logic [2*WIDTH-1:0] fixProd;
    logic [WIDTH-1:0]   fixQuot, fixRem;

    assign fixProd = negReg    ? (~accReg + 1'b1) : accReg;
    assign fixQuot = negReg    ? (~accReg[WIDTH-1:0] + 1'b1) : accReg[WIDTH-1:0];
    assign fixRem  = remNegReg ? (~accReg[2*WIDTH-1:WIDTH] + 1'b1) : accReg[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg   <= IDLE;
            countReg   <= '0;
            accReg     <= '0;
            operandReg <= '0;
            negReg     <= 1'b0;
            remNegReg  <= 1'b0;
            divZeroReg <= 1'b0;
            isDivReg   <= 1'b0;
            hiReg      <= '0;
            loReg      <= '0;
            doneReg    <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            countReg   <= countNext;
            accReg     <= accNext;
            operandReg <= operandNext;
            negReg     <= negNext;
            remNegReg  <= remNegNext;
            divZeroReg <= divZeroNext;
            isDivReg   <= isDivNext;
            hiReg      <= hiNext;
            loReg      <= loNext;
            doneReg    <= doneNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        countNext   = countReg;
        accNext     = accReg;
        operandNext = operandReg;
        negNext     = negReg;
        remNegNext  = remNegReg;
        divZeroNext = divZeroReg;
        isDivNext   = isDivReg;
        hiNext      = hiReg;
        loNext      = loReg;
        doneNext    = 1'b0;

        case (stateReg)
            IDLE: begin
                if (hi_we) hiNext = wdata;
                if (lo_we) loNext = wdata;
                if (start && !flush) begin
                    stateNext   = op[1] ? DIV : MUL;
                    countNext   = '0;
                    isDivNext   = op[1];
                    negNext     = aNeg ^ bNeg;
                    remNegNext  = aNeg;
                    divZeroNext = (src_b == '0);
                    if (op[1]) begin
                        accNext     = {{WIDTH{1'b0}}, magA};
                        operandNext = magB;
                    end else begin
                        accNext     = {{WIDTH{1'b0}}, magB};
                        operandNext = magA;
                    end
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    stateNext = IDLE;
                end else begin
                    accNext   = (stateReg == DIV) ? divStep : mulStep;
                    countNext = countReg + 1'b1;
                    if (countReg == LAST_COUNT) stateNext = FIX;
                end
            end
            FIX: begin
                stateNext = IDLE;
                if (!flush) begin
                    doneNext = 1'b1;
                    if (isDivReg) begin
                        // Divide by zero leaves the dividend in the remainder, which the
                        // sign fix turns back into src_a; only the quotient needs forcing.
                        hiNext = fixRem;
                        loNext = divZeroReg ? {WIDTH{1'b1}} : fixQuot;
                    end else begin
                        {hiNext, loNext} = fixProd;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy      = (stateReg != IDLE);
    assign done      = doneReg;
    assign stall_req = busy & (hilo_read | hi_we | lo_we | start);
    assign hi        = hiReg;
    assign lo        = loReg;

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: a signed 32-bit instance and an unsigned-only 8-bit instance,
// checked against a plain-arithmetic reference model.
module tb_mips_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start32, flush32, hilo32, hiWe32, loWe32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, wdata32, hi32, lo32;
    logic        busy32, done32, stall32;

    logic        start8, flush8, hilo8, hiWe8, loWe8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wdata8, hi8, lo8;
    logic        busy8, done8, stall8;

    mips_muldiv #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .src_a(a32), .src_b(b32),
        .flush(flush32), .hilo_read(hilo32), .hi_we(hiWe32), .lo_we(loWe32), .wdata(wdata32),
        .busy(busy32), .done(done32), .stall_req(stall32), .hi(hi32), .lo(lo32)
    );

    mips_muldiv #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
        .flush(flush8), .hilo_read(hilo8), .hi_we(hiWe8), .lo_we(loWe8), .wdata(wdata8),
        .busy(busy8), .done(done8), .stall_req(stall8), .hi(hi8), .lo(lo8)
    );

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: sign-extend per the op, then use native multiply, divide and modulo.
    function automatic void refModel(input int w, input bit sgnEn, input logic [1:0] op,
                                     input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] hiE, output logic [63:0] loE);
        logic [63:0] mask, ea, eb, p;
        longint      sa, sb;
        bit          sgn;
        mask = (64'd1 << w) - 64'd1;
        sgn  = sgnEn && !op[0];
        ea   = (sgn && a[w-1]) ? (a | ~mask) : a;
        eb   = (sgn && b[w-1]) ? (b | ~mask) : b;
        if (!op[1]) begin
            p   = ea * eb;
            loE = p & mask;
            hiE = (p >> w) & mask;
        end else if (b == 64'd0) begin
            hiE = a;
            loE = mask;
        end else if (sgn) begin
            sa  = $signed(ea);
            sb  = $signed(eb);
            loE = 64'(sa / sb) & mask;
            hiE = 64'(sa % sb) & mask;
        end else begin
            loE = (a / b) & mask;
            hiE = (a % b) & mask;
        end
    endfunction

    function automatic logic [63:0] pickOperand(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return mask;
            2:       return 64'd1 << (w - 1);
            3:       return 64'd1;
            4:       return mask ^ (64'd1 << (w - 1));
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    // Issues one op, waits for done and checks against the model. Returns in the done
    // cycle so the next call issues back-to-back.
    task automatic runCheck(input bit narrow, input logic [1:0] op, input logic [63:0] a,
                            input logic [63:0] b, output logic [63:0] hiO, output logic [63:0] loO);
        int          w, lat, busyCnt;
        logic [63:0] hiE, loE;
        w = narrow ? 8 : 32;
        if (narrow) begin start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        else begin start32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
        lat     = -1;
        busyCnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (narrow ? done8 : done32) begin
                lat = k;
                break;
            end
            if (narrow ? busy8 : busy32) busyCnt++;
        end
        hiO = narrow ? {56'd0, hi8} : {32'd0, hi32};
        loO = narrow ? {56'd0, lo8} : {32'd0, lo32};
        refModel(w, !narrow, op, a, b, hiE, loE);
        $display("[TB] w=%0d op=%0d a=%0h b=%0h hi=%0h lo=%0h lat=%0d", w, op, a, b, hiO, loO, lat);
        checkVal("latency", 64'(lat), 64'(w + 1));
        checkVal("busy_cycles", 64'(busyCnt), 64'(w + 1));
        checkVal("hi_model", hiO, hiE);
        checkVal("lo_model", loO, loE);
    endtask

    // Starts a 32-bit DIV and flushes it so the flush is sampled at edge E0+n.
    task automatic flushAt(input int n);
        int doneSeen;
        start32 = 1'b1; op32 = 2'b10; a32 = 32'd1000; b32 = 32'd7;
        @(posedge clk);
        #1 start32 = 1'b0;
        repeat (n - 1) @(posedge clk);
        #1 flush32 = 1'b1;
        @(posedge clk);
        #1 flush32 = 1'b0;
        @(negedge clk);
        $display("[TB] flush at E0+%0d busy=%0d hi=%0h lo=%0h", n, busy32, hi32, lo32);
        checkVal("flush_busy", 64'(busy32), 64'd0);
        checkVal("flush_hi", 64'(hi32), 64'h0000AAAA);
        checkVal("flush_lo", 64'(lo32), 64'h00005555);
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) doneSeen = 1;
        end
        checkVal("flush_no_done", 64'(doneSeen), 64'd0);
    endtask

    initial begin
        logic [63:0] hiO, loO;
        int          stallCnt, doneK, stallAtDone;

        {start32, flush32, hilo32, hiWe32, loWe32, op32, a32, b32, wdata32} = '0;
        {start8, flush8, hilo8, hiWe8, loWe8, op8, a8, b8, wdata8} = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        $display("[TB] reset busy=%0d done=%0d hi=%0h lo=%0h", busy32, done32, hi32, lo32);
        checkVal("rst_busy", 64'(busy32), 64'd0);
        checkVal("rst_done", 64'(done32), 64'd0);
        checkVal("rst_hi", 64'(hi32), 64'd0);
        checkVal("rst_lo", 64'(lo32), 64'd0);
        checkVal("rst_stall", 64'(stall32), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Directed 32-bit results
        runCheck(1'b0, 2'b00, 64'hFFFFFFFF, 64'h2, hiO, loO);
        checkVal("mult_hi", hiO, 64'hFFFFFFFF);
        checkVal("mult_lo", loO, 64'hFFFFFFFE);
        @(negedge clk);
        checkVal("done_pulse_width", 64'(done32), 64'd0);
        runCheck(1'b0, 2'b01, 64'hFFFFFFFF, 64'h2, hiO, loO);
        checkVal("multu_hi", hiO, 64'h1);
        checkVal("multu_lo", loO, 64'hFFFFFFFE);
        runCheck(1'b0, 2'b10, 64'hFFFFFFF9, 64'h2, hiO, loO);
        checkVal("div_neg_hi", hiO, 64'hFFFFFFFF);
        checkVal("div_neg_lo", loO, 64'hFFFFFFFD);
        runCheck(1'b0, 2'b11, 64'h7, 64'h0, hiO, loO);
        checkVal("divu_zero_hi", hiO, 64'h7);
        checkVal("divu_zero_lo", loO, 64'hFFFFFFFF);
        runCheck(1'b0, 2'b10, 64'h80000000, 64'hFFFFFFFF, hiO, loO);
        checkVal("div_ovf_hi", hiO, 64'h0);
        checkVal("div_ovf_lo", loO, 64'h80000000);

        // hilo_read raised at E0+5 and held
        @(posedge clk);
        #1 start32 = 1'b1; op32 = 2'b10; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk);
        #1 start32 = 1'b0;
        stallCnt = 0; doneK = -1; stallAtDone = -1;
        for (int k = 0; k < 100; k++) begin
            if (k == 5) hilo32 = 1'b1;
            @(negedge clk);
            if (done32) begin
                doneK = k;
                stallAtDone = int'(stall32);
                break;
            end
            if (stall32) stallCnt++;
            @(posedge clk);
            #1;
        end
        hilo32 = 1'b0;
        $display("[TB] stall window cycles=%0d done_at=%0d", stallCnt, doneK);
        checkVal("stall_cycles", 64'(stallCnt), 64'd28);
        checkVal("stall_done_at", 64'(doneK), 64'd33);
        checkVal("stall_drop_at_done", 64'(stallAtDone), 64'd0);

        // MTHI / MTLO in IDLE
        @(posedge clk);
        #1 hiWe32 = 1'b1; wdata32 = 32'h1234;
        @(posedge clk);
        #1 hiWe32 = 1'b0;
        $display("[TB] mthi hi=%0h done=%0d", hi32, done32);
        checkVal("mthi_hi", 64'(hi32), 64'h1234);
        checkVal("mthi_no_done", 64'(done32), 64'd0);
        hiWe32 = 1'b1; wdata32 = 32'hAAAA;
        @(posedge clk);
        #1 hiWe32 = 1'b0; loWe32 = 1'b1; wdata32 = 32'h5555;
        @(posedge clk);
        #1 loWe32 = 1'b0;
        checkVal("mtlo_lo", 64'(lo32), 64'h5555);

        // Flush mid-divide, flush in FIX, flush together with start
        flushAt(10);
        flushAt(33);
        start32 = 1'b1; flush32 = 1'b1; op32 = 2'b00;
        @(posedge clk);
        #1 start32 = 1'b0; flush32 = 1'b0;
        checkVal("flush_beats_start", 64'(busy32), 64'd0);

        // Asynchronous reset in the middle of a multiply
        start32 = 1'b1; op32 = 2'b00; a32 = 32'h12345; b32 = 32'h6789;
        @(posedge clk);
        #1 start32 = 1'b0;
        repeat (5) @(posedge clk);
        #2 hilo32 = 1'b1;
        #1 checkVal("pre_rst_stall", 64'(stall32), 64'd1);
        rst = 1'b0;
        #1;
        $display("[TB] mid-op reset busy=%0d stall=%0d hi=%0h lo=%0h", busy32, stall32, hi32, lo32);
        checkVal("midrst_busy", 64'(busy32), 64'd0);
        checkVal("midrst_stall", 64'(stall32), 64'd0);
        checkVal("midrst_done", 64'(done32), 64'd0);
        checkVal("midrst_hi", 64'(hi32), 64'd0);
        checkVal("midrst_lo", 64'(lo32), 64'd0);
        hilo32 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        // Narrow unsigned-only instance
        runCheck(1'b1, 2'b00, 64'h80, 64'h02, hiO, loO);
        checkVal("w8_mult_hi", hiO, 64'h01);
        checkVal("w8_mult_lo", loO, 64'h00);
        for (int i = 0; i < 1000; i++)
            runCheck(1'b1, 2'($urandom_range(0, 3)), pickOperand(8), pickOperand(8), hiO, loO);
        for (int i = 0; i < 200; i++)
            runCheck(1'b0, 2'($urandom_range(0, 3)), pickOperand(32), pickOperand(32), hiO, loO);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
